// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and state encoding for the shift-add multiplier
package mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/adder_with_parameter.sv
// rtl/adder_with_parameter.sv - WIDTH-bit ripple adder with carry-in and carry-out
module adder_with_parameter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - sequential shift-and-add unsigned multiplier, one multiplier bit per cycle
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ack,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [3*WIDTH-1:0] run_vec;

  assign addend = mplier_q[0] ? mcand_q : '0;

  adder_with_parameter #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (acc_hi_q),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(carry)
  );

  // {carry, sum, acc_lo, mplier} shifted right by one; mplier[0] has been consumed
  assign run_vec = {carry, sum, acc_lo_q, mplier_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_hi_d = '0;
          acc_lo_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          mcand_d   = '0;
          mplier_d  = '0;
          acc_hi_d  = '0;
          acc_lo_d  = '0;
          cnt_d     = '0;
          product_d = '0;
          state_d   = IDLE;
        end else begin
          acc_hi_d = run_vec[3*WIDTH-1:2*WIDTH];
          acc_lo_d = run_vec[2*WIDTH-1:WIDTH];
          mplier_d = run_vec[WIDTH-1:0];
          cnt_d    = cnt_q + CNT_W'(1);
          // last iteration: the upper 2*WIDTH bits of the shifted vector are the product
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_d = run_vec[3*WIDTH-1:WIDTH];
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          mcand_d   = '0;
          mplier_d  = '0;
          acc_hi_d  = '0;
          acc_lo_d  = '0;
          cnt_d     = '0;
          product_d = '0;
          state_d   = IDLE;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - self-checking bench for shift_add_mul_ctrl (WIDTH=8 and WIDTH=16)
module tb_shift_add_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        ack = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ack16 = 1'b0;
  logic        abort16 = 1'b0;
  logic        busy16;
  logic        done16;
  logic [31:0] product16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_mul_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ack(ack), .abort(abort),
    .busy(busy), .done(done), .product(product)
  );

  shift_add_mul_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .ack(ack16), .abort(abort16),
    .busy(busy16), .done(done16), .product(product16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          ack_dly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one full transaction: start pulse, count busy cycles, check product, hold, ack
  task automatic do_mul(input logic [7:0] ta, input logic [7:0] tbv, input int ack_dly,
                        input logic [15:0] exp, input string name);
    int n;
    int guard;
    @(posedge clk); #1;
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    n = 0; guard = 0;
    @(negedge clk);
    while (!done && guard < 40) begin
      if (busy) n++;
      guard++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, 64'(n), 64'd8);
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " product"}, 64'(product), 64'(exp));
    for (int i = 0; i < ack_dly; i++) @(negedge clk);
    chk({name, " held"}, 64'({done, product}), 64'({1'b1, exp}));
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk({name, " idle_after_ack"}, 64'({busy, done, product}), 64'({2'b00, exp}));
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({name, " done_reached"}, 64'(done), 64'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    longint     model;
    int         n16;
    int         guard;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   2};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01,  0};
    vecs[2] = '{8'd0,   8'd200, 16'd0,     1};
    vecs[3] = '{8'd200, 8'd0,   16'd0,     3};
    vecs[4] = '{8'd1,   8'd1,   16'd1,     0};
    vecs[5] = '{8'd128, 8'd2,   16'd256,   5};
    vecs[6] = '{8'd170, 8'd85,  16'd14450, 1};
    vecs[7] = '{8'd255, 8'd1,   16'd255,   4};

    #3;
    chk("reset_outputs", 64'({busy, done, product}), 64'd0);
    chk("reset_outputs16", 64'({busy16, done16, product16}), 64'd0);
    #19;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_mul(vecs[i].a, vecs[i].b, vecs[i].ack_dly, vecs[i].exp, "table");

    // start held high through RUN while operands wander; then start+ack together in DONE
    @(posedge clk); #1;
    a = 8'd9; b = 8'd5; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    wait_done("held_start");
    chk("held_start product", 64'(product), 64'd45);
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_ack idle", 64'({busy, done}), 64'd0);
    @(negedge clk);
    chk("start_ack no_new_op", 64'({busy, done, product}), 64'({2'b00, 16'd45}));

    // asynchronous reset at RUN iteration 4
    @(posedge clk); #1;
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midrun", 64'({busy, done, product}), 64'd0);
    #2;
    rst_n = 1'b1;
    do_mul(8'd7, 8'd6, 1, 16'd42, "after_reset");

    // abort in RUN at iteration 4
    @(posedge clk); #1;
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_run", 64'({busy, done, product}), 64'd0);
    do_mul(8'd7, 8'd6, 0, 16'd42, "after_abort");

    // abort together with ack in DONE: abort wins and clears product
    @(posedge clk); #1;
    a = 8'd20; b = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    wait_done("abort_done");
    chk("abort_done product_before", 64'(product), 64'd400);
    @(posedge clk); #1;
    abort = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; ack = 1'b0;
    @(negedge clk);
    chk("abort_done cleared", 64'({busy, done, product}), 64'd0);

    // abort in IDLE is ignored
    do_mul(8'd3, 8'd5, 0, 16'd15, "pre_idle_abort");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle ignored", 64'({busy, done, product}), 64'({2'b00, 16'd15}));

    // WIDTH=16 extreme operands
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = '0; b16 = '0;
    n16 = 0; guard = 0;
    @(negedge clk);
    while (!done16 && guard < 80) begin
      if (busy16) n16++;
      guard++;
      @(negedge clk);
    end
    chk("w16 busy_cycles", 64'(n16), 64'd16);
    chk("w16 product", 64'({done16, product16}), 64'({1'b1, 32'hFFFE0001}));
    @(posedge clk); #1;
    ack16 = 1'b1;
    @(posedge clk); #1;
    ack16 = 1'b0;

    // randomized operands against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model = longint'(ra) * longint'(rb);
      do_mul(ra, rb, int'($urandom_range(0, 5)), 16'(model), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
